lsu_port: RTL and testbench
===========================

LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 The module SHALL have no parameters; all datapaths are 32 bits.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  core presents a load/store request.
REQ-005 req_ready  out  1  request accepted at a rising edge where req_valid && req_ready.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data; the low byte or half is used for B/H.
REQ-010 resp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-011 resp_rdata  out  32  load result; 0 for stores and errors.
REQ-012 resp_err  out  1  misaligned address or illegal funct3; valid with resp_valid.
REQ-013 mem_write_enable  out  1  write strobe to the word memory.
REQ-014 mem_address  out  32  word index = {2'b00, addr_q[31:2]}.
REQ-015 mem_data_in  out  32  word written to memory.
REQ-016 mem_data_out  in  32  memory read word; valid the cycle after the edge that sampled mem_address.

Function
REQ-017 States SHALL be IDLE, RD, CAP, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 On acceptance, addr, funct3, we and wdata SHALL be registered (addr_q, etc.); inputs are ignored outside IDLE.
REQ-019 Error conditions SHALL be:
- H/HU with addr[0]=1;
- W with addr[1:0]!=0;
- funct3 011/110/111;
- store with funct3 100/101.
REQ-020 Error request: IDLE->RESP with resp_err=1 and resp_rdata=0; no memory access or write.
REQ-021 Load (accepted at edge N): IDLE->RD->CAP->RESP; resp_valid is high between edges N+2 and N+3; IDLE again at N+3.
REQ-022 Load data extraction:
- CAP SHALL register the extracted value from mem_data_out into resp_rdata.
- Byte order is little-endian.
- B/BU select byte addr_q[1:0]; H/HU select half addr_q[1].
- B/H sign-extend; BU/HU zero-extend; W passes the word through.
REQ-023 SW: IDLE->WR->RESP; in WR, mem_write_enable=1 and mem_data_in=wdata_q; resp_valid is high between edges N+1 and N+2.
REQ-024 SB/SH (read-modify-write): IDLE->RD->CAP->WR->RESP.
- CAP registers mem_data_out into a merge register.
- WR writes the merge word with only the addressed byte/half lane replaced by wdata_q[7:0]/[15:0].
- resp_valid is high between edges N+3 and N+4.
REQ-025 mem_write_enable SHALL be high only in WR, for exactly one cycle per store, decoded from state (not from inputs).
REQ-026 mem_address SHALL be driven from addr_q in every state; mem_data_in SHALL be 0 outside WR.
REQ-027 resp_valid SHALL be high only in RESP; resp_rdata/resp_err SHALL hold until the next RESP.
REQ-028 Back-to-back: a request held valid during RESP SHALL NOT be accepted until the following IDLE cycle.
REQ-029 Address wrap: word index uses addr_q[31:2] unmodified; no range check.

Reset
REQ-030 While rst_n=0, the block SHALL immediately (asynchronously) be in IDLE with outputs:
- req_ready=1;
- resp_valid=0, resp_err=0, resp_rdata=0;
- mem_write_enable=0, mem_address=0, mem_data_in=0.
REQ-031 Reset asserted in RD/CAP/WR SHALL abort the operation: no write after reset, and no resp_valid for the aborted request.

Verification
REQ-032 SW addr 0x0000_0010 wdata 0xDEADBEEF -> one write, mem_address=4, mem_data_in=0xDEADBEEF; resp_valid 2 cycles after acceptance, resp_err=0.
REQ-033 Memory word 4 = 0xDEADBEEF, LB addr 0x13 -> 0xFFFFFFDE; LBU 0x12 -> 0x000000AD; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF; each 3 cycles after acceptance.
REQ-034 Word 4 = 0xDEADBEEF, SB addr 0x11 wdata 0x55 -> memory word 0xDEAD55EF; SH addr 0x12 wdata 0x1234 -> 0x123455EF.
REQ-035 LW addr 0x0000_0002 and SH addr 0x0000_0001 -> resp_err=1, resp_rdata=0, mem_write_enable never high.
REQ-036 rst_n low for one cycle while in CAP of an SB -> no write occurs, no resp_valid; next request is accepted normally.

Source files
------------

// File: rtl/lsu_port_if.sv
// Load/store port bundle: core request/response handshake plus word-memory side.
interface lsu_port_if;
  // Core request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Core response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // Word memory
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  // LSU side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write_enable, mem_address, mem_data_in
  );

  // Core/memory side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write_enable, mem_address, mem_data_in
  );
endinterface

// File: rtl/lsu_port.sv
// Single-outstanding load/store unit port onto a 32-bit word memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module lsu_port (
  input logic      clk,
  input logic      rst_n,
  lsu_port_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] word_q;   // word to be written in StWr
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merge_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Classify the incoming request as illegal (bad size code or misaligned).
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // Extract the addressed lane from the memory word (little-endian).
  always_comb begin
    byte_sel = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_sel = bus.mem_data_out[7:0];
      2'd1:    byte_sel = bus.mem_data_out[15:8];
      2'd2:    byte_sel = bus.mem_data_out[23:16];
      default: byte_sel = bus.mem_data_out[31:24];
    endcase
    half_sel = addr_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
    // funct3[2] selects zero extension (BU/HU)
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      2'b01:   load_val = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      default: load_val = bus.mem_data_out;
    endcase
  end

  // Replace only the addressed byte/half of the read word with the store data.
  always_comb begin
    merge_word = bus.mem_data_out;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_word[7:0]   = wdata_q[7:0];
        2'd1:    merge_word[15:8]  = wdata_q[7:0];
        2'd2:    merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = wdata_q[15:0];
    end else begin
      merge_word[15:0] = wdata_q[15:0];
    end
  end

  // Request sequencing FSM; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            funct3_q <= bus.req_funct3;
            we_q     <= bus.req_we;
            if (req_err) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= StResp;
            end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
              word_q  <= bus.req_wdata;
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: state_q <= StCap;
        StCap: begin
          if (we_q) begin
            word_q  <= merge_word;
            state_q <= StWr;
          end else begin
            rdata_q <= load_val;
            err_q   <= 1'b0;
            state_q <= StResp;
          end
        end
        StWr: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= StResp;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready        = (state_q == StIdle);
  assign bus.resp_valid       = (state_q == StResp);
  assign bus.resp_rdata       = rdata_q;
  assign bus.resp_err         = err_q;
  assign bus.mem_write_enable = (state_q == StWr);
  assign bus.mem_address      = {2'b00, addr_q[31:2]};
  assign bus.mem_data_in      = (state_q == StWr) ? word_q : 32'h0;

endmodule

// File: tb/tb_lsu_port.sv
// Directed table-driven bench for lsu_port with a simple word-memory model.
module tb_lsu_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lsu_port_if bus ();

  lsu_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word memory: synchronous write, read data registered one edge after address.
  logic [31:0] mem [64];
  logic [31:0] mem_rd = 32'h0;
  int          wr_total = 0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;

  assign bus.mem_data_out = mem_rd;

  always @(posedge clk) begin
    mem_rd <= mem[bus.mem_address[5:0]];
    if (bus.mem_write_enable) begin
      mem[bus.mem_address[5:0]] <= bus.mem_data_in;
      wr_total <= wr_total + 1;
      wr_addr  <= bus.mem_address;
      wr_data  <= bus.mem_data_in;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // edges after acceptance until resp_valid rises
    int          exp_wr;
    logic [31:0] exp_word;  // memory word 4 after the request
  } vec_t;

  // Issue one request and wait (bounded) for its response.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output logic rdy_in_resp,
                         output logic pulse_end_ok);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata       = bus.resp_rdata;
    err         = bus.resp_err;
    rdy_in_resp = bus.req_ready;
    @(posedge clk);
    #1;
    pulse_end_ok = !bus.resp_valid && bus.req_ready && (bus.resp_rdata === rdata);
  endtask

  vec_t vecs[14];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rdy;
    logic        pend;
    int          wr0;
    int          resp_seen;

    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 3'b100, 32'h12, 32'h0,        32'h000000AD, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 3'b000, 32'h11, 32'h55,       32'h0,        1'b0, 3, 1, 32'hDEAD55EF};
    vecs[7]  = '{1'b1, 3'b001, 32'h12, 32'h1234,     32'h0,        1'b0, 3, 1, 32'h123455EF};
    vecs[8]  = '{1'b0, 3'b010, 32'h02, 32'h0,        32'h0,        1'b1, 0, 0, 32'h123455EF};
    vecs[9]  = '{1'b1, 3'b001, 32'h01, 32'hFFFF,     32'h0,        1'b1, 0, 0, 32'h123455EF};
    vecs[10] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 0, 0, 32'h123455EF};
    vecs[11] = '{1'b1, 3'b100, 32'h10, 32'hAA,       32'h0,        1'b1, 0, 0, 32'h123455EF};
    vecs[12] = '{1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 0, 32'h123455EF};
    vecs[13] = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00001234, 1'b0, 2, 0, 32'h123455EF};

    bus.req_valid  = 1'b1;  // ignored while in reset
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'hFFFF_FFFC;
    bus.req_wdata  = 32'h0;

    // Reset values
    #13;
    check("rst_req_ready",  {31'h0, bus.req_ready},        32'h1);
    check("rst_resp_valid", {31'h0, bus.resp_valid},       32'h0);
    check("rst_resp_err",   {31'h0, bus.resp_err},         32'h0);
    check("rst_resp_rdata", bus.resp_rdata,                32'h0);
    check("rst_mem_we",     {31'h0, bus.mem_write_enable}, 32'h0);
    check("rst_mem_addr",   bus.mem_address,               32'h0);
    check("rst_mem_din",    bus.mem_data_in,               32'h0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      wr0 = wr_total;
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, rdy, pend);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_ready_in_resp", i), {31'h0, rdy}, 32'h0);
      check($sformatf("v%0d_pulse_end", i), {31'h0, pend}, 32'h1);
      check($sformatf("v%0d_writes", i), 32'(wr_total - wr0), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_mem_word4", i), mem[4], vecs[i].exp_word);
      if (vecs[i].exp_wr == 1) check($sformatf("v%0d_wr_addr", i), wr_addr, 32'h4);
    end

    // Back-to-back: request held valid through RESP is taken only in the next IDLE.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b011;  // illegal -> RESP right after acceptance
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1;
    check("b2b_first_resp", {31'h0, bus.resp_valid}, 32'h1);
    check("b2b_ready_in_resp", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_idle_no_resp", {31'h0, bus.resp_valid}, 32'h0);
    check("b2b_idle_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("b2b_second_resp", {31'h0, bus.resp_valid}, 32'h1);
    @(posedge clk);
    #1;

    // Reset in CAP of an SB aborts it: no write, no response.
    wr0 = wr_total;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h11;
    bus.req_wdata  = 32'hAA;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);  // RD -> CAP
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
    check("abort_mem_we", {31'h0, bus.mem_write_enable}, 32'h0);
    check("abort_mem_addr", bus.mem_address, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) resp_seen++;
    end
    check("abort_writes", 32'(wr_total - wr0), 32'h0);
    check("abort_resp", 32'(resp_seen), 32'h0);
    check("abort_mem_word4", mem[4], 32'h123455EF);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, rdy, pend);
    check("post_abort_rdata", rd, 32'h123455EF);
    check("post_abort_latency", 32'(lat), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
